barreira_combiner: RTL

Parametrised N-channel barrier combiner: debounces each raw barrier sensor input, applies a per-channel enable mask, and combines the enabled channels by a run-time selectable vote (OR, AND, majority). A three-state hold FSM keeps the combined `Barreira` output asserted for a fixed number of cycles after the vote drops. It replaces the fixed two-input barrier OR in the gate-control path and feeds the same downstream consumer.

---
 rtl/barreira_pkg.sv | 26 ++
 rtl/barreira_debounce.sv | 47 ++++
 rtl/barreira_combiner.sv | 110 +++++++++++
 3 files changed

// File: rtl/barreira_pkg.sv
// Shared definitions for the barrier combiner: vote mode encodings, hold FSM
// state type and a fixed-width popcount helper.
package barreira_pkg;

  // Vote mode encodings carried on Modo; the fourth code is reserved and votes as OR.
  localparam logic [1:0] MODO_OR  = 2'd0;
  localparam logic [1:0] MODO_AND = 2'd1;
  localparam logic [1:0] MODO_MAJ = 2'd2;

  typedef enum logic [1:0] {
    LIVRE    = 2'd0,
    ATIVA    = 2'd1,
    RETENCAO = 2'd2
  } estado_t;

  // Popcount over the widest supported channel vector; callers zero-extend.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/barreira_debounce.sv
// Single-channel debouncer: the stable bit only follows the raw input after
// DEB_CYCLES consecutive samples that disagree with it.
// Ports: Clock, Reset (sync, active-high), raw (sensor bit), estavel (stable bit).
module barreira_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic estavel
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

  logic          s_q, s_d;
  logic [CW-1:0] c_q, c_d;

  // Count disagreeing samples; the DEB_CYCLES-th one commits the new value.
  always_comb begin
    s_d = s_q;
    c_d = c_q;
    if (raw != s_q) begin
      if (c_q >= C_LAST) begin
        s_d = raw;
        c_d = '0;
      end else begin
        c_d = c_q + CW'(1);
      end
    end else begin
      c_d = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s_q <= 1'b0;
      c_q <= '0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign estavel = s_q;

endmodule

// File: rtl/barreira_combiner.sv
// N-channel barrier combiner: debounced channels, masked vote (OR/AND/majority)
// and a hold FSM that stretches the combined output after the vote drops.
// Ports: Clock, Reset (sync, active-high), Barreira_in (raw sensors),
// Mascara (channel enable), Modo (vote mode), Barreira (combined, registered),
// Ativos (debounced channels, unmasked), Evento (pulse on LIVRE->ATIVA).
module barreira_combiner
  import barreira_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [N_CH-1:0] Barreira_in,
  input  logic [N_CH-1:0] Mascara,
  input  logic [1:0]      Modo,
  output logic            Barreira,
  output logic [N_CH-1:0] Ativos,
  output logic            Evento
);

  localparam int unsigned PW        = $clog2(N_CH + 1);
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD_CYCLES);

  for (genvar g = 0; g < N_CH; g++) begin : g_deb
    barreira_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .Clock  (Clock),
      .Reset  (Reset),
      .raw    (Barreira_in[g]),
      .estavel(Ativos[g])
    );
  end

  logic [N_CH-1:0] ativos_en_c;
  logic [PW-1:0]   pop_en_c;
  logic [PW-1:0]   pop_mask_c;
  logic            vote_c;

  // Vote on the enabled debounced channels; an empty mask never votes.
  always_comb begin
    ativos_en_c = Ativos & Mascara;
    pop_en_c    = PW'(popcount16(16'(ativos_en_c)));
    pop_mask_c  = PW'(popcount16(16'(Mascara)));
    case (Modo)
      MODO_AND: vote_c = (pop_mask_c != '0) && (ativos_en_c == Mascara);
      // Strict majority: a tie does not vote.
      MODO_MAJ: vote_c = {pop_en_c, 1'b0} > {1'b0, pop_mask_c};
      default:  vote_c = |ativos_en_c;
    endcase
  end

  estado_t    estado_q, estado_d;
  logic [7:0] h_q, h_d;
  logic       barreira_d;
  logic       evento_d;

  // Hold FSM: a returning vote wins over an expiring hold counter.
  always_comb begin
    estado_d = estado_q;
    h_d      = h_q;
    evento_d = 1'b0;
    case (estado_q)
      LIVRE: begin
        if (vote_c) begin
          estado_d = ATIVA;
          evento_d = 1'b1;
        end
      end
      ATIVA: begin
        if (!vote_c) begin
          if (HOLD_INIT == 8'd0) begin
            estado_d = LIVRE;
          end else begin
            estado_d = RETENCAO;
            h_d      = HOLD_INIT;
          end
        end
      end
      RETENCAO: begin
        if (vote_c) begin
          estado_d = ATIVA;
        end else if (h_q == 8'd1) begin
          estado_d = LIVRE;
        end else begin
          h_d = h_q - 8'd1;
        end
      end
      default: estado_d = LIVRE;
    endcase
    barreira_d = (estado_d != LIVRE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q <= LIVRE;
      h_q      <= '0;
      Barreira <= 1'b0;
      Evento   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      h_q      <= h_d;
      Barreira <= barreira_d;
      Evento   <= evento_d;
    end
  end

endmodule
